mem_access_unit: RTL and testbench

Parametrised load/store unit between the multicycle core's execute stage and the memory request/response channels. Generalises the core's in-line load/store handling to XLEN of 32 or 64 bits and adds misaligned access support by splitting any access that crosses a bus word into two bus transactions. Produces sign/zero-extended load data and per-unit performance counts.

---
 rtl/mem_access_unit_pkg.sv | 41 ++++
 rtl/mem_access_unit_align.sv | 54 +++++
 rtl/mem_access_unit.sv | 272 +++++++++++++++++++++++++++
 tb/tb_mem_access_unit.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_unit_pkg.sv
// Shared types and helpers for the load/store unit: FSM state encoding,
// access size codes and bus geometry derived from XLEN.
package mem_access_unit_pkg;

    typedef enum logic [5:0] {
        ST_IDLE  = 6'b000001,
        ST_REQ0  = 6'b000010,
        ST_RESP0 = 6'b000100,
        ST_REQ1  = 6'b001000,
        ST_RESP1 = 6'b010000,
        ST_DONE  = 6'b100000
    } mau_state_e;

    typedef enum logic [1:0] {
        SZ_BYTE  = 2'd0,
        SZ_HALF  = 2'd1,
        SZ_WORD  = 2'd2,
        SZ_DWORD = 2'd3
    } mau_size_e;

    localparam int XLEN_32 = 32;
    localparam int XLEN_64 = 64;

    function automatic int bus_bytes(input int xlen);
        return xlen / 8;
    endfunction

    function automatic int bus_lg(input int xlen);
        return $clog2(xlen / 8);
    endfunction

    function automatic logic xlen_legal(input int xlen);
        return (xlen == XLEN_32) || (xlen == XLEN_64);
    endfunction

    // Doubleword accesses only exist on a 64-bit bus.
    function automatic logic size_legal(input logic [1:0] size, input int xlen);
        return xlen_legal(xlen) && ((size != SZ_DWORD) || (xlen == XLEN_64));
    endfunction

endpackage

// File: rtl/mem_access_unit_align.sv
// Byte-lane steering for the load/store unit: store strobes and data for both
// bus beats, and load merge plus sign/zero extension.
module lsu_align
    import mem_access_unit_pkg::*;
#(
    parameter int XLEN = 32,
    localparam int B  = bus_bytes(XLEN),
    localparam int LB = bus_lg(XLEN)
) (
    input  logic [1:0]      i_size,
    input  logic [LB-1:0]   i_off,
    input  logic            i_unsigned,
    input  logic [XLEN-1:0] i_wdata,
    input  logic [XLEN-1:0] i_beat0,
    input  logic [XLEN-1:0] i_beat1,
    output logic [B-1:0]    o_strb0,
    output logic [B-1:0]    o_strb1,
    output logic [XLEN-1:0] o_data0,
    output logic [XLEN-1:0] o_data1,
    output logic [XLEN-1:0] o_load
);

    logic [LB:0]        w_n;
    logic [2*B-1:0]     w_strb_all;
    logic [2*XLEN-1:0]  w_wd_all;
    logic [XLEN-1:0]    w_keep;
    logic [XLEN-1:0]    w_low;
    logic               w_sign;

    // Shift an n-byte mask and the store data across a double-width window;
    // the upper half is what spills into the second bus word.
    always_comb begin
        w_n        = {{LB{1'b0}}, 1'b1} << i_size;
        w_strb_all = (~({(2*B){1'b1}} << w_n)) << i_off;
        w_wd_all   = {{XLEN{1'b0}}, i_wdata} << {i_off, 3'b000};
        o_strb0    = w_strb_all[B-1:0];
        o_strb1    = w_strb_all[2*B-1:B];
        o_data0    = w_wd_all[XLEN-1:0];
        o_data1    = w_wd_all[2*XLEN-1:XLEN];
    end

    // Load: right-justify the access, keep n bytes, replicate the top kept bit.
    always_comb begin
        w_keep = ~({XLEN{1'b1}} << {w_n, 3'b000});
        w_low  = XLEN'({i_beat1, i_beat0} >> {i_off, 3'b000}) & w_keep;
        w_sign = |(w_low & (w_keep ^ (w_keep >> 1)));
        if (w_sign && !i_unsigned) begin
            o_load = w_low | ~w_keep;
        end else begin
            o_load = w_low;
        end
    end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit between the execute stage and the memory bus. Accesses that
// cross a bus word are split into two bus transactions.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [1:0]          req_size,
    input  logic                req_unsigned,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [XLEN-1:0]     req_wdata,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [XLEN-1:0]     rsp_rdata,
    output logic                rsp_err,
    output logic [ADDR_W-1:0]   Address,
    output logic                MemWrite,
    output logic                MemRead,
    output logic [XLEN-1:0]     Write_data,
    output logic [XLEN/8-1:0]   Write_strb,
    input  logic                Mem_Req_Ack,
    input  logic [XLEN-1:0]     Read_data,
    input  logic                Read_data_Valid,
    output logic                Read_data_Ack,
    output logic [31:0]         perf_split_cnt,
    output logic [31:0]         perf_stall_cnt
);

    localparam int B  = bus_bytes(XLEN);
    localparam int LB = bus_lg(XLEN);
    localparam logic [LB+1:0]   B_SUM  = B[LB+1:0];
    localparam logic [ADDR_W-1:0] B_ADDR = ADDR_W'(B);

    mau_state_e         r_state;
    logic               r_we;
    logic [1:0]         r_size;
    logic               r_uns;
    logic [ADDR_W-1:0]  r_base;
    logic [LB-1:0]      r_off;
    logic [XLEN-1:0]    r_wdata;
    logic               r_split;
    logic [XLEN-1:0]    r_beat0;

    logic               r_req_ready;
    logic               r_rsp_valid;
    logic [XLEN-1:0]    r_rsp_rdata;
    logic               r_rsp_err;
    logic [ADDR_W-1:0]  r_addr_o;
    logic               r_mem_write;
    logic               r_mem_read;
    logic [XLEN-1:0]    r_wr_data;
    logic [B-1:0]       r_wr_strb;
    logic               r_rd_ack;
    logic [31:0]        r_split_cnt;
    logic [31:0]        r_stall_cnt;

    logic               w_idle;
    logic               w_accept;
    logic               w_legal;
    logic [LB:0]        w_n_req;
    logic [LB+1:0]      w_end_req;
    logic               w_split_req;
    logic [ADDR_W-1:0]  w_base_req;
    logic [1:0]         w_size;
    logic [LB-1:0]      w_off;
    logic               w_uns;
    logic [XLEN-1:0]    w_wdata;
    logic [XLEN-1:0]    w_beat0;
    logic [B-1:0]       w_strb0;
    logic [B-1:0]       w_strb1;
    logic [XLEN-1:0]    w_data0;
    logic [XLEN-1:0]    w_data1;
    logic [XLEN-1:0]    w_load;

    assign w_idle      = (r_state == ST_IDLE);
    assign w_accept    = req_valid & r_req_ready;
    assign w_legal     = size_legal(req_size, XLEN);
    assign w_n_req     = {{LB{1'b0}}, 1'b1} << req_size;
    assign w_end_req   = {2'b00, req_addr[LB-1:0]} + {1'b0, w_n_req};
    assign w_split_req = (w_end_req > B_SUM);
    assign w_base_req  = {req_addr[ADDR_W-1:LB], {LB{1'b0}}};

    // In IDLE the aligner sees the live request so beat0 can be registered on accept.
    assign w_size  = w_idle ? req_size            : r_size;
    assign w_off   = w_idle ? req_addr[LB-1:0]    : r_off;
    assign w_uns   = w_idle ? req_unsigned        : r_uns;
    assign w_wdata = w_idle ? req_wdata           : r_wdata;
    assign w_beat0 = (r_state == ST_RESP0) ? Read_data : r_beat0;

    lsu_align #(.XLEN(XLEN)) u_align (
        .i_size     (w_size),
        .i_off      (w_off),
        .i_unsigned (w_uns),
        .i_wdata    (w_wdata),
        .i_beat0    (w_beat0),
        .i_beat1    (Read_data),
        .o_strb0    (w_strb0),
        .o_strb1    (w_strb1),
        .o_data0    (w_data0),
        .o_data1    (w_data1),
        .o_load     (w_load)
    );

    // Access sequencer: all bus and response outputs are registered here.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_we        <= 1'b0;
            r_size      <= 2'd0;
            r_uns       <= 1'b0;
            r_base      <= {ADDR_W{1'b0}};
            r_off       <= {LB{1'b0}};
            r_wdata     <= {XLEN{1'b0}};
            r_split     <= 1'b0;
            r_beat0     <= {XLEN{1'b0}};
            r_req_ready <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= {XLEN{1'b0}};
            r_rsp_err   <= 1'b0;
            r_addr_o    <= {ADDR_W{1'b0}};
            r_mem_write <= 1'b0;
            r_mem_read  <= 1'b0;
            r_wr_data   <= {XLEN{1'b0}};
            r_wr_strb   <= {B{1'b0}};
            r_rd_ack    <= 1'b0;
            r_split_cnt <= 32'd0;
            r_stall_cnt <= 32'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_req_ready <= 1'b1;
                    if (w_accept) begin
                        r_req_ready <= 1'b0;
                        r_we        <= req_we;
                        r_size      <= req_size;
                        r_uns       <= req_unsigned;
                        r_base      <= w_base_req;
                        r_off       <= req_addr[LB-1:0];
                        r_wdata     <= req_wdata;
                        r_beat0     <= {XLEN{1'b0}};
                        if (!w_legal) begin
                            r_split     <= 1'b0;
                            r_rsp_valid <= 1'b1;
                            r_rsp_err   <= 1'b1;
                            r_rsp_rdata <= {XLEN{1'b0}};
                            r_state     <= ST_DONE;
                        end else begin
                            r_split     <= w_split_req;
                            r_addr_o    <= w_base_req;
                            r_mem_read  <= ~req_we;
                            r_mem_write <= req_we;
                            r_wr_data   <= req_we ? w_data0 : {XLEN{1'b0}};
                            r_wr_strb   <= req_we ? w_strb0 : {B{1'b0}};
                            r_state     <= ST_REQ0;
                        end
                    end
                end
                ST_REQ0: begin
                    if (Mem_Req_Ack) begin
                        if (r_we && r_split) begin
                            r_addr_o  <= r_base + B_ADDR;
                            r_wr_data <= w_data1;
                            r_wr_strb <= w_strb1;
                            r_state   <= ST_REQ1;
                        end else begin
                            r_addr_o    <= {ADDR_W{1'b0}};
                            r_mem_read  <= 1'b0;
                            r_mem_write <= 1'b0;
                            r_wr_data   <= {XLEN{1'b0}};
                            r_wr_strb   <= {B{1'b0}};
                            if (!r_we) begin
                                r_rd_ack <= 1'b1;
                                r_state  <= ST_RESP0;
                            end else begin
                                r_rsp_valid <= 1'b1;
                                r_rsp_rdata <= {XLEN{1'b0}};
                                r_state     <= ST_DONE;
                            end
                        end
                    end else begin
                        r_stall_cnt <= r_stall_cnt + 32'd1;
                    end
                end
                ST_RESP0: begin
                    if (Read_data_Valid) begin
                        r_rd_ack <= 1'b0;
                        r_beat0  <= Read_data;
                        if (r_split) begin
                            r_addr_o   <= r_base + B_ADDR;
                            r_mem_read <= 1'b1;
                            r_state    <= ST_REQ1;
                        end else begin
                            r_rsp_valid <= 1'b1;
                            r_rsp_rdata <= w_load;
                            r_state     <= ST_DONE;
                        end
                    end else begin
                        r_stall_cnt <= r_stall_cnt + 32'd1;
                    end
                end
                ST_REQ1: begin
                    if (Mem_Req_Ack) begin
                        r_addr_o    <= {ADDR_W{1'b0}};
                        r_mem_read  <= 1'b0;
                        r_mem_write <= 1'b0;
                        r_wr_data   <= {XLEN{1'b0}};
                        r_wr_strb   <= {B{1'b0}};
                        if (!r_we) begin
                            r_rd_ack <= 1'b1;
                            r_state  <= ST_RESP1;
                        end else begin
                            r_rsp_valid <= 1'b1;
                            r_rsp_rdata <= {XLEN{1'b0}};
                            r_state     <= ST_DONE;
                        end
                    end else begin
                        r_stall_cnt <= r_stall_cnt + 32'd1;
                    end
                end
                ST_RESP1: begin
                    if (Read_data_Valid) begin
                        r_rd_ack    <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_rdata <= w_load;
                        r_state     <= ST_DONE;
                    end else begin
                        r_stall_cnt <= r_stall_cnt + 32'd1;
                    end
                end
                ST_DONE: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_rsp_err   <= 1'b0;
                        r_rsp_rdata <= {XLEN{1'b0}};
                        r_req_ready <= 1'b1;
                        r_split_cnt <= r_split_cnt + {31'd0, r_split};
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_req_ready <= 1'b0;
                    r_rsp_valid <= 1'b0;
                    r_rsp_err   <= 1'b0;
                    r_mem_read  <= 1'b0;
                    r_mem_write <= 1'b0;
                    r_rd_ack    <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready      = r_req_ready;
    assign rsp_valid      = r_rsp_valid;
    assign rsp_rdata      = r_rsp_rdata;
    assign rsp_err        = r_rsp_err;
    assign Address        = r_addr_o;
    assign MemWrite       = r_mem_write;
    assign MemRead        = r_mem_read;
    assign Write_data     = r_wr_data;
    assign Write_strb     = r_wr_strb;
    assign Read_data_Ack  = r_rd_ack;
    assign perf_split_cnt = r_split_cnt;
    assign perf_stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit (XLEN=32): expected bus beats and
// responses are queued by the stimulus and checked by a negedge monitor.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] Address;
    logic        MemWrite;
    logic        MemRead;
    logic [31:0] Write_data;
    logic [3:0]  Write_strb;
    logic        Mem_Req_Ack;
    logic [31:0] Read_data;
    logic        Read_data_Valid;
    logic        Read_data_Ack;
    logic [31:0] perf_split_cnt;
    logic [31:0] perf_stall_cnt;

    logic        ack_en;
    logic        rv_en;
    logic [31:0] mem [0:255];
    logic [7:0]  rd_idx = 8'd0;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int acc_cyc  = 0;
    bit seen     = 1'b0;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  strb;
        logic [31:0] data;
    } bus_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
    } rsp_t;

    bus_t bus_q[$];
    rsp_t rsp_q[$];

    mem_access_unit #(.XLEN(32), .ADDR_W(32)) dut (
        .clk             (clk),
        .rst             (rst),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_we          (req_we),
        .req_size        (req_size),
        .req_unsigned    (req_unsigned),
        .req_addr        (req_addr),
        .req_wdata       (req_wdata),
        .rsp_valid       (rsp_valid),
        .rsp_ready       (rsp_ready),
        .rsp_rdata       (rsp_rdata),
        .rsp_err         (rsp_err),
        .Address         (Address),
        .MemWrite        (MemWrite),
        .MemRead         (MemRead),
        .Write_data      (Write_data),
        .Write_strb      (Write_strb),
        .Mem_Req_Ack     (Mem_Req_Ack),
        .Read_data       (Read_data),
        .Read_data_Valid (Read_data_Valid),
        .Read_data_Ack   (Read_data_Ack),
        .perf_split_cnt  (perf_split_cnt),
        .perf_stall_cnt  (perf_stall_cnt)
    );

    always #5 clk = ~clk;

    // Zero-wait memory unless ack_en/rv_en are pulled low.
    assign Mem_Req_Ack     = (MemRead | MemWrite) & ack_en;
    assign Read_data_Valid = Read_data_Ack & rv_en;
    assign Read_data       = mem[rd_idx];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic exp_bus(input logic we, input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
        bus_t e;
        e.we = we; e.addr = a; e.strb = s; e.data = d;
        bus_q.push_back(e);
    endtask

    task automatic exp_rsp(input logic [31:0] d, input logic err, input int lat);
        rsp_t e;
        e.rdata = d; e.err = err; e.lat = lat;
        rsp_q.push_back(e);
    endtask

    task automatic issue(input logic we, input logic [1:0] sz, input logic uns,
                         input logic [31:0] a, input logic [31:0] wd);
        int k;
        k = 0;
        while (req_ready !== 1'b1 && k < 100) begin
            @(posedge clk); #1;
            k++;
        end
        if (req_ready !== 1'b1) chk("issue_wait_ready", 64'(req_ready), 64'(1'b1));
        req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
        req_addr = a; req_wdata = wd;
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (req_ready !== 1'b1 && k < 100) begin
            @(posedge clk); #1;
            k++;
        end
        if (req_ready !== 1'b1) chk("wait_idle_timeout", 64'(req_ready), 64'(1'b1));
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Monitor: compares acked bus beats and consumed responses with the queues.
    initial forever begin
        @(negedge clk);
        if (req_valid === 1'b1 && req_ready === 1'b1) begin
            acc_cyc = cyc;
        end
        if (Mem_Req_Ack === 1'b1) begin
            if (MemRead === 1'b1) rd_idx = Address[9:2];
            if (bus_q.size() == 0) begin
                chk("bus_unexpected", 64'({MemWrite, Address}), 64'd0);
            end else begin
                bus_t e;
                e = bus_q.pop_front();
                chk("bus_hdr", 64'({MemWrite, Address, Write_strb}), 64'({e.we, e.addr, e.strb}));
                chk("bus_data", 64'(Write_data), 64'(e.data));
            end
        end
        if (rsp_valid === 1'b1) begin
            if (rsp_q.size() == 0) begin
                chk("rsp_unexpected", 64'(rsp_valid), 64'd0);
            end else begin
                if (!seen) begin
                    seen = 1'b1;
                    chk("rsp_latency", 64'(cyc - acc_cyc), 64'(rsp_q[0].lat));
                end
                if (rsp_ready === 1'b1) begin
                    rsp_t e;
                    e = rsp_q.pop_front();
                    chk("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
                    chk("rsp_err", 64'(rsp_err), 64'(e.err));
                    seen = 1'b0;
                end
            end
        end
    end

    initial begin
        #200000;
        n_checks++;
        n_fail++;
        $display("FAIL global_timeout: got cycle %0d expected completion", cyc);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        rst = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0;
        req_unsigned = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;
        rsp_ready = 1'b1; ack_en = 1'b1; rv_en = 1'b1;
        for (int i = 0; i < 256; i++) mem[i] = 32'd0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_bus",   64'({Address, MemRead, MemWrite, Read_data_Ack, Write_strb}), 64'd0);
        chk("rst_wdata", 64'(Write_data), 64'd0);
        chk("rst_rsp",   64'({rsp_valid, rsp_err, req_ready, rsp_rdata}), 64'd0);
        chk("rst_perf",  64'({perf_split_cnt, perf_stall_cnt}), 64'd0);
        rst = 1'b1;
        chk("rdy_before_edge", 64'(req_ready), 64'd0);
        @(posedge clk); #1;
        chk("rdy_after_release", 64'(req_ready), 64'd1);

        // Aligned word load
        mem[8'h40] = 32'hDEADBEEF;
        exp_bus(1'b0, 32'h100, 4'h0, 32'h0);
        exp_rsp(32'hDEADBEEF, 1'b0, 3);
        issue(1'b0, 2'd2, 1'b0, 32'h100, 32'h0);
        chk("req_ready_busy", 64'(req_ready), 64'd0);
        wait_idle();

        // Byte/half loads with sign and zero extension
        mem[8'h40] = 32'h80FF0000;
        exp_bus(1'b0, 32'h100, 4'h0, 32'h0);
        exp_rsp(32'hFFFFFF80, 1'b0, 3);
        issue(1'b0, 2'd0, 1'b0, 32'h103, 32'h0);
        wait_idle();
        exp_bus(1'b0, 32'h100, 4'h0, 32'h0);
        exp_rsp(32'h00000080, 1'b0, 3);
        issue(1'b0, 2'd0, 1'b1, 32'h103, 32'h0);
        wait_idle();
        exp_bus(1'b0, 32'h100, 4'h0, 32'h0);
        exp_rsp(32'h000080FF, 1'b0, 3);
        issue(1'b0, 2'd1, 1'b1, 32'h102, 32'h0);
        wait_idle();

        // Aligned stores
        exp_bus(1'b1, 32'h300, 4'hF, 32'hCAFEF00D);
        exp_rsp(32'h0, 1'b0, 2);
        issue(1'b1, 2'd2, 1'b0, 32'h300, 32'hCAFEF00D);
        wait_idle();
        exp_bus(1'b1, 32'h300, 4'h2, 32'h0000A500);
        exp_rsp(32'h0, 1'b0, 2);
        issue(1'b1, 2'd0, 1'b0, 32'h301, 32'h000000A5);
        wait_idle();
        chk("split_cnt_0", 64'(perf_split_cnt), 64'd0);

        // Split word store
        exp_bus(1'b1, 32'h200, 4'hC, 32'h33440000);
        exp_bus(1'b1, 32'h204, 4'h3, 32'h00001122);
        exp_rsp(32'h0, 1'b0, 3);
        issue(1'b1, 2'd2, 1'b0, 32'h202, 32'h11223344);
        wait_idle();
        chk("split_cnt_1", 64'(perf_split_cnt), 64'd1);

        // Split half load
        mem[8'h81] = 32'hAB000000;
        mem[8'h82] = 32'h000000CD;
        exp_bus(1'b0, 32'h204, 4'h0, 32'h0);
        exp_bus(1'b0, 32'h208, 4'h0, 32'h0);
        exp_rsp(32'hFFFFCDAB, 1'b0, 5);
        issue(1'b0, 2'd1, 1'b0, 32'h207, 32'h0);
        wait_idle();
        chk("split_cnt_2", 64'(perf_split_cnt), 64'd2);
        chk("stall_cnt_0", 64'(perf_stall_cnt), 64'd0);

        // Ack withheld 5 cycles, then response back-pressured 3 cycles
        mem[8'h40] = 32'hDEADBEEF;
        ack_en = 1'b0;
        exp_bus(1'b0, 32'h100, 4'h0, 32'h0);
        exp_rsp(32'hDEADBEEF, 1'b0, 8);
        issue(1'b0, 2'd2, 1'b0, 32'h100, 32'h0);
        for (int i = 0; i < 5; i++) begin
            chk("stall_bus_stable", 64'({Address, MemRead, MemWrite, req_ready}), 64'({32'h100, 1'b1, 1'b0, 1'b0}));
            @(posedge clk); #1;
        end
        ack_en = 1'b1;
        rsp_ready = 1'b0;
        for (int k = 0; k < 20 && rsp_valid !== 1'b1; k++) begin
            @(posedge clk); #1;
        end
        for (int i = 0; i < 3; i++) begin
            chk("hold_rsp", 64'({rsp_valid, req_ready, rsp_rdata}), 64'({1'b1, 1'b0, 32'hDEADBEEF}));
            @(posedge clk); #1;
        end
        rsp_ready = 1'b1;
        wait_idle();
        chk("stall_cnt_5", 64'(perf_stall_cnt), 64'd5);

        // Illegal size on a 32-bit bus
        exp_rsp(32'h0, 1'b1, 1);
        issue(1'b0, 2'd3, 1'b0, 32'h100, 32'h0);
        chk("illegal_no_bus", 64'({MemRead, MemWrite}), 64'd0);
        wait_idle();

        // Reset while waiting for the second read beat
        exp_bus(1'b0, 32'h204, 4'h0, 32'h0);
        exp_bus(1'b0, 32'h208, 4'h0, 32'h0);
        issue(1'b0, 2'd1, 1'b0, 32'h207, 32'h0);
        repeat (3) begin
            @(posedge clk); #1;
        end
        chk("in_resp1_ack", 64'(Read_data_Ack), 64'd1);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("rst_mid_outs", 64'({Read_data_Ack, rsp_valid, req_ready, MemRead}), 64'd0);
        chk("rst_mid_perf", 64'({perf_split_cnt, perf_stall_cnt}), 64'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rst_mid_ready", 64'(req_ready), 64'd1);
        repeat (5) @(posedge clk);
        #1;

        chk("bus_q_drained", 64'(bus_q.size()), 64'd0);
        chk("rsp_q_drained", 64'(rsp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
